// File: rtl/bank_cmd_arbiter_if.sv
// Command-bus handshake between the bank FSMs and the command arbiter.
interface bank_cmd_arbiter_if #(
  parameter int unsigned NUM_BANKS = 8,
  parameter int unsigned ROW_BITS  = 16
);
  localparam int unsigned BankW = $clog2(NUM_BANKS);

  logic [NUM_BANKS-1:0]          ba_issue;
  logic [3*NUM_BANKS-1:0]        ba_cmd;
  logic [ROW_BITS*NUM_BANKS-1:0] ba_addr;
  logic [NUM_BANKS-1:0]          stall;
  logic                          cmd_valid;
  logic [2:0]                    cmd_type;
  logic [BankW-1:0]              cmd_bank;
  logic [ROW_BITS-1:0]           cmd_addr;
  logic                          init_done;

  // Bank-FSM side
  modport master (
    output ba_issue, ba_cmd, ba_addr,
    input  stall, cmd_valid, cmd_type, cmd_bank, cmd_addr, init_done
  );

  // Arbiter side
  modport slave (
    input  ba_issue, ba_cmd, ba_addr,
    output stall, cmd_valid, cmd_type, cmd_bank, cmd_addr, init_done
  );
endinterface

// File: rtl/bank_cmd_arbiter.sv
// Shares one DRAM command bus among NUM_BANKS bank FSMs. Refresh first, otherwise
// round-robin, subject to the tRRD / tCCD / tWTR inter-bank gaps. Grant is registered.
module bank_cmd_arbiter #(
  parameter int unsigned NUM_BANKS   = 8,
  parameter int unsigned ROW_BITS    = 16,
  parameter int unsigned T_RRD       = 4,
  parameter int unsigned T_CCD       = 4,
  parameter int unsigned T_WTR       = 6,
  parameter int unsigned INIT_CYCLES = 16
) (
  input logic               clk,
  input logic               rst,
  bank_cmd_arbiter_if.slave bus
);

  localparam int unsigned BankW = $clog2(NUM_BANKS);
  localparam int unsigned InitW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int unsigned TMaxA = (T_RRD > T_CCD) ? T_RRD : T_CCD;
  localparam int unsigned TMaxB = (TMaxA > T_WTR) ? TMaxA : T_WTR;
  localparam int unsigned TMax  = (TMaxB > 1) ? TMaxB : 1;
  localparam int unsigned CntW  = $clog2(TMax) + 1;

  localparam logic [CntW-1:0] RrdLoad = CntW'((T_RRD > 0) ? T_RRD - 1 : 0);
  localparam logic [CntW-1:0] CcdLoad = CntW'((T_CCD > 0) ? T_CCD - 1 : 0);
  localparam logic [CntW-1:0] WtrLoad = CntW'((T_WTR > 0) ? T_WTR - 1 : 0);

  localparam logic [2:0] CmdNop = 3'd0;
  localparam logic [2:0] CmdAct = 3'd1;
  localparam logic [2:0] CmdRd  = 3'd2;
  localparam logic [2:0] CmdWr  = 3'd3;
  localparam logic [2:0] CmdPre = 3'd4;
  localparam logic [2:0] CmdRef = 3'd5;

  typedef enum logic {StInit, StRun} state_t;

  state_t               r_state, w_state_next;
  logic [InitW-1:0]     r_init_cnt;
  logic [BankW-1:0]     r_rr_ptr;
  logic [CntW-1:0]      r_trrd_cnt, r_tccd_cnt, r_twtr_cnt;
  logic                 r_cmd_valid;
  logic [2:0]           r_cmd_type;
  logic [BankW-1:0]     r_cmd_bank;
  logic [ROW_BITS-1:0]  r_cmd_addr;

  logic [NUM_BANKS-1:0] w_req, w_elig, w_ref;
  logic                 w_grant, w_win_ref;
  logic [BankW-1:0]     w_win;
  logic [2:0]           w_win_cmd;
  logic [ROW_BITS-1:0]  w_win_addr;
  logic [NUM_BANKS-1:0] w_stall;

  // Per-bank request decode and timing eligibility
  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    logic [2:0] w_cmd;
    assign w_cmd      = bus.ba_cmd[3*gi +: 3];
    assign w_req[gi]  = bus.ba_issue[gi] && (w_cmd != CmdNop);
    assign w_ref[gi]  = bus.ba_issue[gi] && (w_cmd == CmdRef);
    assign w_elig[gi] = bus.ba_issue[gi] &&
                        ((w_cmd == CmdAct && r_trrd_cnt == '0) ||
                         (w_cmd == CmdRd  && r_tccd_cnt == '0 && r_twtr_cnt == '0) ||
                         (w_cmd == CmdWr  && r_tccd_cnt == '0) ||
                         (w_cmd == CmdPre) || (w_cmd == CmdRef));
  end

  // Winner selection: lowest-index REF, else first eligible bank from rr_ptr upward
  always_comb begin
    w_grant   = 1'b0;
    w_win_ref = 1'b0;
    w_win     = '0;
    if (r_state == StRun) begin
      for (int k = 0; k < NUM_BANKS; k++) begin
        if (!w_grant && w_ref[k]) begin
          w_grant   = 1'b1;
          w_win_ref = 1'b1;
          w_win     = BankW'(k);
        end
      end
      for (int k = 0; k < NUM_BANKS; k++) begin
        if (!w_grant && w_elig[(int'(r_rr_ptr) + k) % NUM_BANKS]) begin
          w_grant = 1'b1;
          w_win   = BankW'((int'(r_rr_ptr) + k) % NUM_BANKS);
        end
      end
    end
  end

  assign w_win_cmd  = bus.ba_cmd[3*int'(w_win) +: 3];
  assign w_win_addr = bus.ba_addr[ROW_BITS*int'(w_win) +: ROW_BITS];

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StInit;
    else     r_state <= w_state_next;
  end

  // FSM next state: leave init after INIT_CYCLES cycles, then stay in run
  always_comb begin
    w_state_next = r_state;
    if (r_state == StInit && r_init_cnt == InitW'(INIT_CYCLES - 1)) w_state_next = StRun;
  end

  // FSM outputs: stall every non-winning real request, everything during init
  always_comb begin
    w_stall = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (r_state == StInit) w_stall[i] = 1'b1;
      else                   w_stall[i] = w_req[i] && !(w_grant && w_win == BankW'(i));
    end
  end

  assign bus.stall     = w_stall;
  assign bus.init_done = (r_state == StRun);

  // Init cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_init_cnt <= '0;
    else if (r_state == StInit) r_init_cnt <= r_init_cnt + 1'b1;
  end

  // Round-robin pointer: moves past a non-REF winner only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_grant && !w_win_ref) begin
      r_rr_ptr <= (w_win == BankW'(NUM_BANKS - 1)) ? '0 : w_win + 1'b1;
    end
  end

  // Timing gap counters: load on grant, else saturating decrement
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_trrd_cnt <= '0;
      r_tccd_cnt <= '0;
      r_twtr_cnt <= '0;
    end else begin
      if (w_grant && w_win_cmd == CmdAct)                          r_trrd_cnt <= RrdLoad;
      else if (r_trrd_cnt != '0)                                   r_trrd_cnt <= r_trrd_cnt - 1'b1;
      if (w_grant && (w_win_cmd == CmdRd || w_win_cmd == CmdWr))   r_tccd_cnt <= CcdLoad;
      else if (r_tccd_cnt != '0)                                   r_tccd_cnt <= r_tccd_cnt - 1'b1;
      if (w_grant && w_win_cmd == CmdWr)                           r_twtr_cnt <= WtrLoad;
      else if (r_twtr_cnt != '0)                                   r_twtr_cnt <= r_twtr_cnt - 1'b1;
    end
  end

  // Registered command bus; bank/addr hold when nothing is granted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd_valid <= 1'b0;
      r_cmd_type  <= '0;
      r_cmd_bank  <= '0;
      r_cmd_addr  <= '0;
    end else if (w_grant) begin
      r_cmd_valid <= 1'b1;
      r_cmd_type  <= w_win_cmd;
      r_cmd_bank  <= w_win;
      r_cmd_addr  <= w_win_addr;
    end else begin
      r_cmd_valid <= 1'b0;
      r_cmd_type  <= '0;
    end
  end

  assign bus.cmd_valid = r_cmd_valid;
  assign bus.cmd_type  = r_cmd_type;
  assign bus.cmd_bank  = r_cmd_bank;
  assign bus.cmd_addr  = r_cmd_addr;

endmodule
